// File: rtl/booth_mult_arb_pkg.sv
// Shared types, defaults and helpers for the booth_mult_arbiter slice:
// FSM state encoding, default widths and the id-width helper.
package booth_mult_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP
    } state_t;

    localparam int DEF_M_SIZE = 4;
    localparam int DEF_R_SIZE = 4;
    localparam int DEF_N_REQ  = 4;

    // Bits needed to index n items, never less than one.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/booth_mult_arbiter_core.sv
// Combinational radix-2 Booth multiplier. The multiplicand is negated at its own
// width, so m = -2^(M_SIZE-1) cannot be negated and gives an unreliable product.
module booth_mult_core #(
    parameter int M_SIZE   = 4,
    parameter int R_SIZE   = 4,
    localparam int RES_SIZE = M_SIZE + R_SIZE
) (
    input  logic [M_SIZE-1:0]   m,
    input  logic [R_SIZE-1:0]   r,
    output logic [RES_SIZE-1:0] res
);

    logic [M_SIZE-1:0]   m_neg;
    logic [RES_SIZE-1:0] m_ext;
    logic [RES_SIZE-1:0] n_ext;
    logic [R_SIZE:0]     rx;
    logic [RES_SIZE-1:0] acc;
    logic [1:0]          pair;

    assign m_neg = ~m + 1'b1;
    assign m_ext = {{R_SIZE{m[M_SIZE-1]}}, m};
    assign n_ext = {{R_SIZE{m_neg[M_SIZE-1]}}, m_neg};
    assign rx    = {r, 1'b0};

    always_comb begin
        acc  = '0;
        pair = 2'b00;
        for (int i = 0; i < R_SIZE; i++) begin
            pair = {rx[i+1], rx[i]};
            case (pair)
                2'b01:   acc = acc + (m_ext << i);
                2'b10:   acc = acc + (n_ext << i);
                default: acc = acc;
            endcase
        end
        res = acc;
    end

endmodule

// File: rtl/booth_mult_arbiter_rr.sv
// Combinational round-robin arbiter: grants the first asserted request found
// searching upward from ptr, wrapping at N_REQ-1 back to 0.
module rr_arbiter
    import booth_mult_arb_pkg::*;
#(
    parameter int  N_REQ = 4,
    localparam int ID_W  = clog2_min1(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx,
    output logic             any
);

    logic [N_REQ-1:0] rot;
    logic [ID_W:0]    sum;

    // Rotate so that bit 0 of rot is the requester at ptr.
    assign rot = N_REQ'({req, req} >> ptr);

    always_comb begin
        any       = 1'b0;
        grant_idx = '0;
        sum       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!any && rot[i]) begin
                any = 1'b1;
                sum = {1'b0, ptr} + (ID_W+1)'(i);
                if (sum >= (ID_W+1)'(N_REQ)) begin
                    sum = sum - (ID_W+1)'(N_REQ);
                end
                grant_idx = sum[ID_W-1:0];
            end
        end
        grant = any ? (N_REQ'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/booth_mult_arbiter.sv
// Round-robin front end sharing one Booth multiplier among N_REQ requesters.
// Optional res_err flag for the non-negatable multiplicand: BOOTH_MULT_ARB_ERR_EN.
module booth_mult_arbiter
    import booth_mult_arb_pkg::*;
#(
    parameter int  M_SIZE      = DEF_M_SIZE,
    parameter int  R_SIZE      = DEF_R_SIZE,
    parameter int  N_REQ       = DEF_N_REQ,
    parameter int  CALC_CYCLES = 1,
    localparam int RES_SIZE    = M_SIZE + R_SIZE,
    localparam int ID_W        = clog2_min1(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*M_SIZE-1:0] req_m,
    input  logic [N_REQ*R_SIZE-1:0] req_r,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [RES_SIZE-1:0]     res_data,
    output logic [ID_W-1:0]         res_id,
`ifdef BOOTH_MULT_ARB_ERR_EN
    output logic                    res_err,
`endif
    output logic                    busy
);

    localparam int CNT_W = clog2_min1(CALC_CYCLES);

    state_t              state_q;
    state_t              state_d;
    logic [N_REQ-1:0]    grant;
    logic [ID_W-1:0]     grant_idx;
    logic                any;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     next_ptr;
    logic [ID_W-1:0]     id_q;
    logic [M_SIZE-1:0]   op_m;
    logic [R_SIZE-1:0]   op_r;
    logic [M_SIZE-1:0]   sel_m;
    logic [R_SIZE-1:0]   sel_r;
    logic [CNT_W-1:0]    cnt;
    logic [RES_SIZE-1:0] core_res;
    logic                take;
    logic                done;

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_arb (
        .req      (req_valid),
        .ptr      (rr_ptr),
        .grant    (grant),
        .grant_idx(grant_idx),
        .any      (any)
    );

    booth_mult_core #(
        .M_SIZE(M_SIZE),
        .R_SIZE(R_SIZE)
    ) u_core (
        .m  (op_m),
        .r  (op_r),
        .res(core_res)
    );

    always_comb begin
        sel_m = '0;
        sel_r = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant_idx == ID_W'(k)) begin
                sel_m = req_m[k*M_SIZE +: M_SIZE];
                sel_r = req_r[k*R_SIZE +: R_SIZE];
            end
        end
    end

    assign take      = (state_q == IDLE) && any;
    assign done      = (state_q == CALC) && (cnt == '0);
    assign next_ptr  = (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
    assign res_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                req_ready = grant;
                if (any) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operands are held in op_m/op_r for the whole multicycle window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_m     <= '0;
            op_r     <= '0;
            id_q     <= '0;
            rr_ptr   <= '0;
            cnt      <= '0;
            res_data <= '0;
            res_id   <= '0;
        end else begin
            if (take) begin
                op_m   <= sel_m;
                op_r   <= sel_r;
                id_q   <= grant_idx;
                rr_ptr <= next_ptr;
                cnt    <= CNT_W'(CALC_CYCLES - 1);
            end
            if ((state_q == CALC) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            if (done) begin
                res_data <= core_res;
                res_id   <= id_q;
            end
        end
    end

`ifdef BOOTH_MULT_ARB_ERR_EN
    logic min_m;

    assign min_m = (op_m == {1'b1, {(M_SIZE-1){1'b0}}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_err <= 1'b0;
        end else if (done) begin
            res_err <= min_m && (op_r != '0);
        end
    end
`endif

endmodule

// File: doc/booth_mult_arbiter.md
Name: booth_mult_arbiter

Overview:
- Shares one combinational Booth multiplier core between N_REQ requesters.
- Round-robin arbitration; one transaction in flight at a time.
- Operands are registered, the core gets CALC_CYCLES of settle time (multicycle path), and the result is registered and returned on a valid/ready output port tagged with the requester index.
- Sits between the DSP-side requesters and the shared multiplier.

Parameters:
- M_SIZE, 4, multiplicand width; must be >= R_SIZE.
- R_SIZE, 4, multiplier width.
- N_REQ, 4, number of requesters; must be >= 2.
- CALC_CYCLES, 1, cycles the latched operands are held before RES is sampled; must be >= 1.
- Derived, not overridable: RES_SIZE = M_SIZE+R_SIZE; ID_W = max(1, clog2(N_REQ)).

Ports:
- clk, in, 1, single clock, rising edge.
- rst, in, 1, asynchronous, active-high reset.
- req_valid, in, N_REQ, per-requester request.
- req_ready, out, N_REQ, one-hot grant/accept; at most one bit high.
- req_m, in, N_REQ*M_SIZE, packed multiplicands; requester k in bits [k*M_SIZE +: M_SIZE].
- req_r, in, N_REQ*R_SIZE, packed multipliers, same packing.
- res_valid, out, 1, result available.
- res_ready, in, 1, consumer accepts result.
- res_data, out, RES_SIZE, signed product.
- res_id, out, ID_W, index of the requester that owns res_data.
- busy, out, 1, high in any state other than IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE, rr_ptr=0, cnt=0. Outputs: req_ready=0, res_valid=0, res_data=0, res_id=0, busy=0.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - req_ready is combinational from req_valid and rr_ptr.
  - Grant goes to the first asserted req_valid searching upward from rr_ptr, wrapping at N_REQ-1 to 0.
  - On a handshake at the clock edge:
    - latch the granted requester's operands into op_m/op_r;
    - latch the grant index into id_q;
    - set rr_ptr = (grant+1) mod N_REQ;
    - set cnt = CALC_CYCLES-1;
    - go to CALC.
  - No request: stay in IDLE; rr_ptr unchanged.
- CALC:
  - op_m/op_r drive the core's M/R inputs; req_ready=0.
  - If cnt != 0, decrement cnt.
  - If cnt == 0: register the core's RES into res_data and id_q into res_id, then go to RESP.
- RESP:
  - res_valid=1; res_data and res_id are held stable.
  - res_ready=1: res_valid drops next cycle; go to IDLE.
  - res_ready=0: stay in RESP indefinitely (backpressure).
- Latency: handshake at cycle t gives res_valid high at t+CALC_CYCLES+1.
- Throughput: one product per CALC_CYCLES+2 cycles, since IDLE always costs one cycle.
- Arithmetic:
  - Both operands are two's complement.
  - res_data = M*R, sign-extended product, exact in RES_SIZE bits.
  - Exception: M = -2^(M_SIZE-1). The core cannot negate this value, so the result is not guaranteed; see the optional feature.
- Requesters must hold req_m/req_r stable while req_valid=1 and req_ready=0. Operands are sampled only on the handshake edge; changes afterwards are ignored.
- Simultaneous requests: exactly one grant; losers keep waiting. Each persistently requesting source is served within N_REQ transactions (no starvation).
- Reset mid-operation: the in-flight transaction is discarded, no result is produced, and rr_ptr returns to 0.
- Ignored inputs: req_valid while busy has no effect; res_ready outside RESP has no effect.

Optional Feature:
- Macro: BOOTH_MULT_ARB_ERR_EN.
- Defined:
  - Adds output res_err (1 bit), registered with res_data and reset to 0.
  - res_err=1 when the latched op_m == -2^(M_SIZE-1) and op_r != 0 (the unreliable case).
  - res_data is still whatever the core produced.
- Undefined: no res_err port exists, and that operand case is unchecked.

Decomposition:
- Package booth_mult_arb_pkg holds:
  - state enum {IDLE, CALC, RESP};
  - the function clog2_min1 used for ID_W;
  - localparam defaults for M_SIZE, R_SIZE, N_REQ.
- One natural sub-module: rr_arbiter, parameterised by N_REQ. It is combinational: inputs req vector and ptr; outputs one-hot grant, grant index, and any.
- The multiplier core itself is instantiated unchanged with its M/R/RES interface.

Test Plan:
1. Reset mid-CALC: assert rst during CALC -> all outputs 0 immediately; no res_valid follows; the next grant honours rr_ptr=0.
2. Single request, defaults: req0, M=3, R=-2 (4'b1110) -> req_ready[0] on the accept cycle; res_valid 2 cycles later; res_data=8'hFA (-6); res_id=0.
3. Simultaneous requests: all 4 valid continuously -> grant order 0,1,2,3,0; exactly one req_ready bit per transaction; each res_id matches its grant.
4. Backpressure: res_ready=0 for 5 cycles with M=-7, R=7 -> res_valid, res_data=8'hCF (-49) and res_id held stable; new requests get req_ready=0 throughout; IDLE is re-entered after res_ready=1.
5. Multicycle core, CALC_CYCLES=3: M=5, R=-8 -> res_valid at t+4; res_data=8'hD8 (-40).
6. Optional feature, BOOTH_MULT_ARB_ERR_EN defined: M=-8, R=-1 -> res_err=1. With M=-8, R=0 -> res_err=0, res_data=0. With M=7, R=-1 -> res_err=0, res_data=8'hF9.
